sdu_reg_dumper: RTL and testbench
=================================

# sdu_reg_dumper

Debug-side initiator for the register file's SDU read port. On request it walks a range of architectural registers through `ra_sdu`/`rd_sdu`, captures each 32-bit value, and streams it out as little-endian bytes over a valid/ready byte interface to the SDU's serial transmitter. It sits between the register file and the SDU UART path and runs with the CPU live, so a dump always reflects write-through (bypassed) values.

## Interface
Parameters:
- `NREG`, 32: number of registers swept in full-dump mode (indices 0..NREG-1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `single`  in  1  sampled with `start`: 1 = dump only `addr`, 0 = dump 0..NREG-1.
- `addr`  in  5  register index for single mode, sampled with `start`.
- `ra_sdu`  out  5  read address to the register file's SDU port.
- `rd_sdu`  in  32  read data from the register file. It is combinational from `ra_sdu`, reads x0 as 0, and includes the same-cycle write bypass.
- `tx_data`  out  8  byte to the transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte this cycle.
- `busy`  out  1  high from the cycle after accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse at dump completion.

## Operation
- States: IDLE, LOAD, SEND, CSUM (only when configured), FIN.
- **IDLE:** when `start`=1, latch `cur` = `single ? addr : 0` and `last` = `single ? addr : NREG-1`, clear `sum`, then go to LOAD. While not in IDLE, `start` is ignored.
- **LOAD:** `ra_sdu` = `cur`. At the clock edge, `word` <= `rd_sdu`, `bidx` <= 0, and the state goes to SEND. If a register-file write to `cur` happens in this cycle, the captured value is the written data.
- **SEND:**
  - Drive `tx_valid`=1 and `tx_data` = `word[8*bidx +: 8]`.
  - On a handshake (`tx_valid && tx_ready`): `sum` += byte (mod 256).
  - If `bidx` < 3, increment `bidx`.
  - Otherwise, if `cur` == `last`, go to CSUM or FIN.
  - Otherwise, `cur` <= `cur`+1 and go to LOAD.
- **CSUM:** drive `tx_valid`=1 and `tx_data` = `sum`. On handshake, go to FIN.
- **FIN:** `done`=1 for exactly this cycle. Next state is IDLE.
- `ra_sdu` holds `cur` in every state, including after the dump ends.
- Byte order: register ascending, then within each register LSB first.
- `tx_data` and `tx_valid` are registered outputs. Once `tx_valid` is asserted, it and `tx_data` stay stable until the handshake.
- **Reset mid-dump:** abort immediately and return all outputs to their reset values. No partial byte is completed, and no `done` is produced.
- **Reset values:** `ra_sdu`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, state IDLE.

## Timing
- `start` high at edge k gives LOAD in cycle k+1 and the first `tx_valid` in cycle k+2.
- With `tx_ready` held at 1, each register costs 5 cycles (1 LOAD + 4 SEND).
  - Full dump: 160 cycles from LOAD entry to the last handshake, plus 1 for CSUM if configured.
  - `done` is asserted in the cycle after the final handshake.
- Backpressure adds exactly one cycle per cycle that `tx_ready` is low while `tx_valid` is high.
- `busy` is high in LOAD, SEND, CSUM and FIN, and low in IDLE.
- `start` in the same cycle as FIN is ignored. A new dump can begin the cycle after `done`.

## Configuration
- `SDU_DUMP_CHECKSUM_EN` defined: CSUM state present. One extra byte is sent after the data bytes: the 8-bit mod-256 sum of all data bytes of this dump.
- `SDU_DUMP_CHECKSUM_EN` undefined: no CSUM state and no `sum` register. FIN follows the last data handshake directly, and the stream carries data bytes only (4 per register).

## Test plan
- **Reset:** assert `rst` mid-SEND with `tx_ready`=0. All outputs go to 0 immediately, with no `done` afterwards.
- **Single mode:** `addr`=5, rf[5]=0xDEADBEEF, `tx_ready`=1.
  - Bytes EF, BE, AD, DE appear on consecutive cycles from k+2.
  - With the macro, a fifth byte 0x38 follows.
  - `done` is asserted one cycle after the last byte.
- **Full dump:** rf[i]=i*0x01010101, `tx_ready`=1.
  - Checker receives 128 bytes with values (i,i,i,i) for i=0..31; x0 gives 00 00 00 00.
  - `done` at LOAD-entry+160 without the macro, +161 with it.
- **Backpressure:** `tx_ready` is 0 for 3 cycles while the byte for `bidx`=2 is presented. `tx_data` stays constant, and total latency grows by exactly 3.
- **Bypass:** in the LOAD cycle of register 7, drive `we`=1, `wa`=7, `wd`=0x12345678 into the register file. The bytes sent are 78 56 34 12.
- **Start while busy:** pulse `start` with `single`=1, `addr`=3 during a full dump. The pulse is ignored: the full dump completes unchanged and a single `done` pulse occurs.

Source files
------------

// File: rtl/sdu_reg_dumper.sv
// sdu_reg_dumper: walks register-file SDU read port and streams values as LSB-first bytes.
// Define SDU_DUMP_CHECKSUM_EN to append a mod-256 checksum byte after the data bytes.
module sdu_reg_dumper #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        single,
    input  logic [4:0]  addr,
    output logic [4:0]  ra_sdu,
    input  logic [31:0] rd_sdu,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
`ifdef SDU_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t      r_state, w_state;
    logic [4:0]  r_cur, w_cur, r_last, w_last;
    logic [31:0] r_word, w_word;
    logic [1:0]  r_bidx, w_bidx, w_nidx;
    logic [7:0]  w_tx_data;
    logic        w_tx_valid, w_hs;
`ifdef SDU_DUMP_CHECKSUM_EN
    logic [7:0]  r_sum, w_sum, w_sum_add;
`endif

    assign ra_sdu = r_cur;
    assign busy   = r_state != S_IDLE;
    assign done   = r_state == S_FIN;
    assign w_hs   = tx_valid && tx_ready;
    assign w_nidx = r_bidx + 2'd1;
`ifdef SDU_DUMP_CHECKSUM_EN
    assign w_sum_add = r_sum + tx_data;
`endif

    always_comb begin
        w_state    = r_state;
        w_cur      = r_cur;
        w_last     = r_last;
        w_word     = r_word;
        w_bidx     = r_bidx;
        w_tx_data  = tx_data;
        w_tx_valid = tx_valid;
`ifdef SDU_DUMP_CHECKSUM_EN
        w_sum      = r_sum;
`endif
        case (r_state)
            S_IDLE: if (start) begin
                w_cur   = single ? addr : 5'd0;
                w_last  = single ? addr : 5'(NREG - 1);
`ifdef SDU_DUMP_CHECKSUM_EN
                w_sum   = '0;
`endif
                w_state = S_LOAD;
            end
            S_LOAD: begin
                w_word     = rd_sdu;
                w_bidx     = '0;
                w_tx_data  = rd_sdu[7:0];
                w_tx_valid = 1'b1;
                w_state    = S_SEND;
            end
            S_SEND: if (w_hs) begin
`ifdef SDU_DUMP_CHECKSUM_EN
                w_sum = w_sum_add;
`endif
                if (r_bidx != 2'd3) begin
                    w_bidx    = w_nidx;
                    w_tx_data = r_word[{w_nidx, 3'd0} +: 8];
                end else if (r_cur == r_last) begin
`ifdef SDU_DUMP_CHECKSUM_EN
                    w_tx_data  = w_sum_add;
                    w_state    = S_CSUM;
`else
                    w_tx_valid = 1'b0;
                    w_state    = S_FIN;
`endif
                end else begin
                    w_cur      = r_cur + 5'd1;
                    w_tx_valid = 1'b0;
                    w_state    = S_LOAD;
                end
            end
`ifdef SDU_DUMP_CHECKSUM_EN
            S_CSUM: if (w_hs) begin
                w_tx_valid = 1'b0;
                w_state    = S_FIN;
            end
`endif
            S_FIN:   w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_last   <= '0;
            r_word   <= '0;
            r_bidx   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
`ifdef SDU_DUMP_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_cur    <= w_cur;
            r_last   <= w_last;
            r_word   <= w_word;
            r_bidx   <= w_bidx;
            tx_data  <= w_tx_data;
            tx_valid <= w_tx_valid;
`ifdef SDU_DUMP_CHECKSUM_EN
            r_sum    <= w_sum;
`endif
        end
    end
endmodule

// File: tb/tb_sdu_reg_dumper.sv
// tb_sdu_reg_dumper: directed self-checking bench for sdu_reg_dumper with a bypassing register-file model.
module tb_sdu_reg_dumper;
`ifdef SDU_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, single = 1'b0, tx_ready = 1'b1;
    logic [4:0]  addr = '0, ra_sdu;
    logic [31:0] rd_sdu;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;
    logic [31:0] rf [32];
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    byte unsigned q[$], e[$];
    int checks = 0, errors = 0, dn, first_v;

    sdu_reg_dumper #(.NREG(32)) dut (
        .clk(clk), .rst(rst), .start(start), .single(single), .addr(addr),
        .ra_sdu(ra_sdu), .rd_sdu(rd_sdu), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign rd_sdu = (ra_sdu == 5'd0) ? 32'd0 : (we && wa == ra_sdu) ? wd : rf[ra_sdu];
    always @(posedge clk) if (we && wa != 5'd0) rf[wa] <= wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_regs(input int lo, input int hi);
        byte unsigned s = 0;
        e.delete();
        for (int i = lo; i <= hi; i++)
            for (int b = 0; b < 4; b++) begin
                e.push_back(i == 0 ? 8'd0 : rf[i][8*b +: 8]);
                s += e[$];
            end
        if (CS == 1) e.push_back(s);
    endtask

    // Caller raises start just before calling; iteration n=0 is the LOAD cycle.
    task automatic collect(input int max_cyc, input int stall_idx, input int stall_len,
                           input int pulse_at, input int we_at, output int done_n);
        int rem = stall_len;
        logic [7:0] h = '0;
        done_n = -1;
        first_v = -1;
        q.delete();
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge clk); #1;
            start = (n == pulse_at);
            if (n == pulse_at) begin single = 1'b1; addr = 5'd3; end
            we = (n == we_at);
            if (done) begin done_n = n; tx_ready = 1'b1; return; end
            if (tx_valid && first_v < 0) first_v = n;
            if (tx_valid && q.size() == stall_idx && rem > 0) begin
                if (rem == stall_len) h = tx_data;
                else chk("bp_hold", {24'd0, tx_data}, {24'd0, h});
                tx_ready = 1'b0;
                rem--;
            end else begin
                if (rem != stall_len && q.size() == stall_idx) chk("bp_release", {24'd0, tx_data}, {24'd0, h});
                tx_ready = 1'b1;
                if (tx_valid) q.push_back(tx_data);
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic cmp_stream(input string tag);
        int bad = 0;
        chk({tag, "_len"}, q.size(), e.size());
        for (int i = 0; i < q.size() && i < e.size(); i++)
            if (q[i] !== e[i]) begin
                bad++;
                chk($sformatf("%s_byte%0d", tag, i), {24'd0, q[i]}, {24'd0, e[i]});
            end
        chk({tag, "_bytes_bad"}, bad, 0);
    endtask

    task automatic after_done(input string tag);
        chk({tag, "_busy_in_fin"}, {31'd0, busy}, 1);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 0);
        chk({tag, "_idle_valid"}, {31'd0, tx_valid}, 0);
    endtask

    task automatic go(input logic s, input logic [4:0] a);
        single = s; addr = a; start = 1'b1;
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
        rf[5] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ra", {27'd0, ra_sdu}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        go(1'b1, 5'd5);
        collect(50, -1, 0, -1, -1, dn);
        chk("single_first_valid", first_v, 1);
        chk("single_done_n", dn, 5 + CS);
        chk("single_ra", {27'd0, ra_sdu}, 5);
        e = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CS == 1) e.push_back(8'h38);
        cmp_stream("single");
        after_done("single");

        rf[5] = 32'h05050505;
        go(1'b0, 5'd9);
        collect(400, -1, 0, -1, -1, dn);
        chk("full_done_n", dn, 160 + CS);
        chk("full_ra", {27'd0, ra_sdu}, 31);
        exp_regs(0, 31);
        cmp_stream("full");
        after_done("full");

        go(1'b1, 5'd12);
        collect(50, 2, 3, -1, -1, dn);
        chk("bp_done_n", dn, 5 + CS + 3);
        exp_regs(12, 12);
        cmp_stream("bp");
        after_done("bp");

        go(1'b1, 5'd7);
        wa = 5'd7; wd = 32'h12345678;
        collect(50, -1, 0, -1, 0, dn);
        chk("byp_done_n", dn, 5 + CS);
        e = '{8'h78, 8'h56, 8'h34, 8'h12};
        if (CS == 1) e.push_back(8'h14);
        cmp_stream("byp");
        after_done("byp");
        rf[7] = 32'h07070707;

        go(1'b0, 5'd0);
        collect(400, -1, 0, 50, -1, dn);
        single = 1'b0;
        chk("busy_start_done_n", dn, 160 + CS);
        exp_regs(0, 31);
        cmp_stream("busy_start");
        after_done("busy_start");

        go(1'b1, 5'd5);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_valid", {31'd0, tx_valid}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ra", {27'd0, ra_sdu}, 0);
        chk("mid_rst_data", {24'd0, tx_data}, 0);
        chk("mid_rst_valid", {31'd0, tx_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || tx_valid || busy) bad++;
        end
        chk("mid_rst_quiet", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
